// File: rtl/mem_wb_skid.sv
// ---------------------------------------------------------------------------
// mem_wb_skid
//
// MEM/WB pipeline stage for the RV64 core. It is a valid/ready stage with a
// 2-entry skid buffer, so o_ready comes straight from a flop and no ready
// path runs back through the pipe. Writeback source selection and x0 write
// suppression happen when an entry is captured. The register-file write port
// therefore sees registered o_wb_data / o_rd / o_reg_write with no logic in
// front of it.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   i_flush             : drop every held entry and the entry presented now
//   i_valid / o_ready   : upstream handshake (o_ready is a flop output)
//   i_pc4, i_imme, i_pc_imm, i_aluout, i_readdata : MEM-stage data fields
//   i_rd, i_wb_sel, i_reg_write                   : writeback control
//   o_valid / i_ready   : downstream handshake
//   o_pc4 .. o_readdata, o_rd                     : held fields of main entry
//   o_reg_write         : held write enable, already cleared for x0
//   o_wb_data           : held, pre-selected writeback value
// ---------------------------------------------------------------------------
module mem_wb_skid #(
   parameter int DATA_WIDTH = 64,
   parameter int RD_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_flush,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_pc4,
   input  logic [DATA_WIDTH-1:0] i_imme,
   input  logic [DATA_WIDTH-1:0] i_pc_imm,
   input  logic [DATA_WIDTH-1:0] i_aluout,
   input  logic [DATA_WIDTH-1:0] i_readdata,
   input  logic [RD_WIDTH-1:0]   i_rd,
   input  logic [2:0]            i_wb_sel,
   input  logic                  i_reg_write,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_pc4,
   output logic [DATA_WIDTH-1:0] o_imme,
   output logic [DATA_WIDTH-1:0] o_pc_imm,
   output logic [DATA_WIDTH-1:0] o_aluout,
   output logic [DATA_WIDTH-1:0] o_readdata,
   output logic [RD_WIDTH-1:0]   o_rd,
   output logic                  o_reg_write,
   output logic [DATA_WIDTH-1:0] o_wb_data
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc4;
      logic [DATA_WIDTH-1:0] imme;
      logic [DATA_WIDTH-1:0] pc_imm;
      logic [DATA_WIDTH-1:0] aluout;
      logic [DATA_WIDTH-1:0] readdata;
      logic [DATA_WIDTH-1:0] wb_data;
      logic [RD_WIDTH-1:0]   rd;
      logic                  reg_write;
   } entry_t;

   entry_t cap_entry;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   ready_q, ready_d;
   logic   acc;
   logic   drn;

   // Handshake qualifiers. Accept uses the registered ready, so nothing
   // combinational from downstream reaches the upstream side.
   assign acc = i_valid & ready_q;
   assign drn = main_valid_q & i_ready;

   // Build the entry as it will be stored: pick the writeback source now and
   // clear the write enable for x0, so the outputs need no decode later.
   always_comb begin
      cap_entry          = '0;
      cap_entry.pc4      = i_pc4;
      cap_entry.imme     = i_imme;
      cap_entry.pc_imm   = i_pc_imm;
      cap_entry.aluout   = i_aluout;
      cap_entry.readdata = i_readdata;
      cap_entry.rd       = i_rd;
      cap_entry.reg_write = i_reg_write & (i_rd != '0);
      case (i_wb_sel)
         3'b000:  cap_entry.wb_data = i_aluout;
         3'b001:  cap_entry.wb_data = i_readdata;
         3'b010:  cap_entry.wb_data = i_pc4;
         3'b011:  cap_entry.wb_data = i_imme;
         3'b100:  cap_entry.wb_data = i_pc_imm;
         default: cap_entry.wb_data = '0;
      endcase
   end

   // Next-state for the two storage slots. Flush clears only the valid
   // flags; data is left alone. Without flush the cases are mutually
   // exclusive in priority order: skid refills main when main drains (no
   // accept is possible then, since ready is low while skid is full), else
   // an accepted entry goes to main if main is free or draining, else to
   // skid, else a drain with nothing behind it empties main.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (i_flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q && drn) begin
         main_d       = skid_q;
         skid_valid_d = 1'b0;
      end else if (acc && (!main_valid_q || drn)) begin
         main_d       = cap_entry;
         main_valid_d = 1'b1;
      end else if (acc && main_valid_q && !drn) begin
         skid_d       = cap_entry;
         skid_valid_d = 1'b1;
      end else if (drn) begin
         main_valid_d = 1'b0;
      end
      ready_d = !skid_valid_d;
   end

   // State registers. Reset clears every field so the write port sees a
   // clean zero entry, and leaves the stage ready to accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
      end
   end

   assign o_ready     = ready_q;
   assign o_valid     = main_valid_q;
   assign o_pc4       = main_q.pc4;
   assign o_imme      = main_q.imme;
   assign o_pc_imm    = main_q.pc_imm;
   assign o_aluout    = main_q.aluout;
   assign o_readdata  = main_q.readdata;
   assign o_rd        = main_q.rd;
   assign o_reg_write = main_q.reg_write;
   assign o_wb_data   = main_q.wb_data;

endmodule

// File: tb/tb_mem_wb_skid.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_skid
//
// Self-checking bench for mem_wb_skid. A reference model holds the stage as
// a 2-deep FIFO queue of raw input entries; the visible outputs are the head
// of that queue (or the last head once it empties), with the writeback value
// and x0 suppression derived from the raw fields. Directed steps cover reset,
// x0, writeback select, skid fill, drain+accept and flush, then a long
// randomised run with occasional flush and reset.
// ---------------------------------------------------------------------------
module tb_mem_wb_skid;

   typedef struct {
      logic [63:0] pc4;
      logic [63:0] imme;
      logic [63:0] pc_imm;
      logic [63:0] aluout;
      logic [63:0] readdata;
      logic [4:0]  rd;
      logic [2:0]  sel;
      logic        rw;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        i_flush;
   logic        i_valid;
   logic        o_ready;
   logic [63:0] i_pc4;
   logic [63:0] i_imme;
   logic [63:0] i_pc_imm;
   logic [63:0] i_aluout;
   logic [63:0] i_readdata;
   logic [4:0]  i_rd;
   logic [2:0]  i_wb_sel;
   logic        i_reg_write;
   logic        o_valid;
   logic        i_ready;
   logic [63:0] o_pc4;
   logic [63:0] o_imme;
   logic [63:0] o_pc_imm;
   logic [63:0] o_aluout;
   logic [63:0] o_readdata;
   logic [4:0]  o_rd;
   logic        o_reg_write;
   logic [63:0] o_wb_data;

   int   vectors;
   int   miscompares;
   ent_t modelQ[$];
   ent_t shown;

   mem_wb_skid #(.DATA_WIDTH(64), .RD_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .i_flush(i_flush),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_pc4(i_pc4), .i_imme(i_imme), .i_pc_imm(i_pc_imm),
      .i_aluout(i_aluout), .i_readdata(i_readdata),
      .i_rd(i_rd), .i_wb_sel(i_wb_sel), .i_reg_write(i_reg_write),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_pc4(o_pc4), .o_imme(o_imme), .o_pc_imm(o_pc_imm),
      .o_aluout(o_aluout), .o_readdata(o_readdata),
      .o_rd(o_rd), .o_reg_write(o_reg_write), .o_wb_data(o_wb_data)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Writeback value an entry should present, straight from the select table.
   function automatic logic [63:0] wbOf(input ent_t e);
      case (e.sel)
         3'd0:    return e.aluout;
         3'd1:    return e.readdata;
         3'd2:    return e.pc4;
         3'd3:    return e.imme;
         3'd4:    return e.pc_imm;
         default: return 64'd0;
      endcase
   endfunction

   function automatic ent_t mkEntry(input logic [63:0] base, input logic [4:0] rd,
                                    input logic [2:0] sel, input logic rw);
      ent_t e;
      e.pc4      = base + 64'h1;
      e.imme     = base + 64'h2;
      e.pc_imm   = base + 64'h3;
      e.aluout   = base + 64'h4;
      e.readdata = base + 64'h5;
      e.rd       = rd;
      e.sel      = sel;
      e.rw       = rw;
      return e;
   endfunction

   function automatic ent_t randEntry();
      ent_t e;
      e.pc4      = {$urandom, $urandom};
      e.imme     = {$urandom, $urandom};
      e.pc_imm   = {$urandom, $urandom};
      e.aluout   = {$urandom, $urandom};
      e.readdata = {$urandom, $urandom};
      e.rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      e.sel      = 3'($urandom);
      e.rw       = 1'($urandom);
      return e;
   endfunction

   // One comparison: counted, and reported as a FAIL line on mismatch.
   task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model's view of the stage.
   task automatic checkOutput();
      logic expRw;
      expRw = shown.rw && (shown.rd != 5'd0);
      checkValue("o_valid",     64'(o_valid),     64'(modelQ.size() > 0));
      checkValue("o_ready",     64'(o_ready),     64'(modelQ.size() < 2));
      checkValue("o_pc4",       o_pc4,            shown.pc4);
      checkValue("o_imme",      o_imme,           shown.imme);
      checkValue("o_pc_imm",    o_pc_imm,         shown.pc_imm);
      checkValue("o_aluout",    o_aluout,         shown.aluout);
      checkValue("o_readdata",  o_readdata,       shown.readdata);
      checkValue("o_rd",        64'(o_rd),        64'(shown.rd));
      checkValue("o_reg_write", 64'(o_reg_write), 64'(expRw));
      checkValue("o_wb_data",   o_wb_data,        wbOf(shown));
   endtask

   // Drive one cycle of inputs, advance the FIFO model across the edge,
   // then check all outputs 1 time unit after the edge.
   task automatic applyStimulus(input logic v, input logic r, input logic f,
                                input logic rs, input ent_t e);
      logic acc;
      logic drn;
      i_valid     = v;
      i_ready     = r;
      i_flush     = f;
      rst         = rs;
      i_pc4       = e.pc4;
      i_imme      = e.imme;
      i_pc_imm    = e.pc_imm;
      i_aluout    = e.aluout;
      i_readdata  = e.readdata;
      i_rd        = e.rd;
      i_wb_sel    = e.sel;
      i_reg_write = e.rw;
      acc = v && (modelQ.size() < 2);
      drn = (modelQ.size() > 0) && r;
      @(posedge clk);
      #1;
      if (rs) begin
         modelQ.delete();
         shown = '{default: '0};
      end else if (f) begin
         modelQ.delete();
      end else begin
         if (drn) void'(modelQ.pop_front());
         if (acc) modelQ.push_back(e);
      end
      if (modelQ.size() > 0) shown = modelQ[0];
      checkOutput();
   endtask

   initial begin
      ent_t a;
      ent_t b;
      ent_t c;
      ent_t d;
      ent_t idle;
      logic [63:0] wbExp [6];
      vectors     = 0;
      miscompares = 0;
      shown       = '{default: '0};
      idle        = '{default: '0};
      wbExp       = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h0};

      // Reset held for two cycles while upstream claims valid data.
      a = mkEntry(64'hA000, 5'd3, 3'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, a);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, a);
      checkValue("reset_valid", 64'(o_valid), 64'd0);
      checkValue("reset_ready", 64'(o_ready), 64'd1);
      checkValue("reset_wb", o_wb_data, 64'd0);

      // Write to x0 must come out with the write enable cleared.
      a = mkEntry(64'hB000, 5'd0, 3'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, a);
      checkValue("x0_reg_write", 64'(o_reg_write), 64'd0);
      checkValue("x0_valid", 64'(o_valid), 64'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);

      // Stream every writeback select, one per cycle.
      for (int i = 0; i < 6; i++) begin
         a = mkEntry(64'h0, 5'd7, 3'(i), 1'b1);
         a.aluout = 64'h11; a.readdata = 64'h22; a.pc4 = 64'h33;
         a.imme = 64'h44; a.pc_imm = 64'h55;
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, a);
         checkValue("wb_sel", o_wb_data, wbExp[i]);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);

      // Skid fill: A to main, B to skid, C refused while stalled.
      a = mkEntry(64'h1000, 5'd1, 3'd0, 1'b1);
      b = mkEntry(64'h2000, 5'd2, 3'd1, 1'b1);
      c = mkEntry(64'h3000, 5'd3, 3'd2, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, a);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, b);
      checkValue("skid_ready_low", 64'(o_ready), 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, c);
      checkValue("skid_hold_a", o_aluout, a.aluout);
      // Release: B moves up (C still refused), then C is taken, then drains.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, c);
      checkValue("release_b", o_aluout, b.aluout);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, c);
      checkValue("release_c", o_aluout, c.aluout);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);
      checkValue("release_empty", 64'(o_valid), 64'd0);

      // Drain and accept in the same edge keeps the skid empty.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, a);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, b);
      checkValue("swap_b", o_aluout, b.aluout);
      checkValue("swap_ready", 64'(o_ready), 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, c);
      checkValue("swap_ready2", 64'(o_ready), 64'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);

      // Flush with skid full and a new entry offered in the flush cycle.
      d = mkEntry(64'h4000, 5'd4, 3'd3, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, a);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, b);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, d);
      checkValue("flush_valid", 64'(o_valid), 64'd0);
      checkValue("flush_ready", 64'(o_ready), 64'd1);
      checkValue("flush_hold", o_aluout, a.aluout);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);
      checkValue("flush_dropped", 64'(o_valid), 64'd0);

      // Randomised traffic with occasional flush and reset.
      for (int n = 0; n < 10000; n++) begin
         applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 40) == 0), ($urandom_range(0, 700) == 0),
                       randEntry());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
